spi_master_multi: RTL and testbench

Parametrised, multi-slave SPI master: successor to the fixed 16-bit mode-0 master used by the clock's peripheral interfaces. Adds configurable frame width, programmable SCK divider, all four CPOL/CPHA modes, a one-hot chip-select bus, and a valid/ready command handshake so the sequencer can queue transfers without edge-detect tricks. Sits between the FPGA control sequencer and the board's SPI devices (DAC, RTC, HV driver shift registers).

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_clk_div.sv | 29 ++
 rtl/spi_master_multi.sv | 187 ++++++++++++++++++
 tb/tb_spi_master_multi.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the multi-slave SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LEAD,
    ST_TRAIL,
    ST_HOLD,
    ST_DONE
  } spi_state_e;

  // Mode encoding is {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int SPI_DATA_W_DEF = 32;
  localparam int SPI_CS_NUM_DEF = 4;

  function automatic logic mode_cpha(input logic [1:0] mode);
    logic r;
    r = 1'b0;
    case (mode)
      SPI_MODE0, SPI_MODE2: r = 1'b0;
      SPI_MODE1, SPI_MODE3: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: loadable down-counter, tick while the count is zero.
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master_multi.sv
// Multi-slave SPI master, all CPOL/CPHA modes, variable frame width.
// Optional SPIM_LSB_FIRST_EN adds the lsb_first input for LSB-first frames.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter  int DATA_W = SPI_DATA_W_DEF,
  parameter  int CS_NUM = SPI_CS_NUM_DEF,
  parameter  int DIV_W  = 8,
  localparam int BC_W   = $clog2(DATA_W + 1),
  localparam int CS_W   = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [BC_W-1:0]   bit_count,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
`ifdef SPIM_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [CS_NUM-1:0] cs_n
);

  spi_state_e        state_q;
  logic [BC_W-1:0]   n_q, cnt_q;
  logic [1:0]        mode_q;
  logic [DIV_W-1:0]  div_q;
  logic [DATA_W-1:0] sh_q, rx_q, rx_data_q;
  logic              lsb_q;
  logic              sck_q, mosi_q, rx_valid_q, busy_q, tx_ready_q;
  logic [CS_NUM-1:0] cs_n_q;

  logic              accept, div_tick, div_load, lsb_in, q_cpha;
  logic [DIV_W-1:0]  div_load_val;
  logic [BC_W-1:0]   n_in, cnt_inc;
  logic [DATA_W-1:0] tx_aligned, sh_shift, rx_shift;
  logic [CS_NUM-1:0] cs_dec_n;

`ifdef SPIM_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  function automatic logic head_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  assign accept  = tx_valid && tx_ready_q;
  assign n_in    = (bit_count == '0) ? BC_W'(DATA_W) : bit_count;
  assign cnt_inc = cnt_q + 1'b1;
  assign q_cpha  = mode_cpha(mode_q);

  // MSB-first frames are left-aligned so the outgoing bit is always the MSB
  assign tx_aligned = lsb_in ? tx_data : (tx_data << (BC_W'(DATA_W) - n_in));
  assign sh_shift   = lsb_q ? (sh_q >> 1) : (sh_q << 1);
  assign rx_shift   = lsb_q ? ((rx_q >> 1) | (DATA_W'(miso) << (n_q - 1'b1)))
                            : {rx_q[DATA_W-2:0], miso};

  always_comb begin
    cs_dec_n = '1;
    for (int i = 0; i < CS_NUM; i++)
      if (cs_sel == CS_W'(i)) cs_dec_n[i] = 1'b0;
  end

  assign div_load     = accept || div_tick;
  assign div_load_val = accept ? clk_div : div_q;

  spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .load_val_i (div_load_val),
    .tick_o     (div_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      cnt_q      <= '0;
      mode_q     <= SPI_MODE0;
      div_q      <= '0;
      sh_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
      lsb_q      <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b1;
      cs_n_q     <= '1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q    <= ST_SETUP;
            n_q        <= n_in;
            cnt_q      <= '0;
            mode_q     <= {cpol, cpha};
            div_q      <= clk_div;
            sh_q       <= tx_aligned;
            rx_q       <= '0;
            lsb_q      <= lsb_in;
            sck_q      <= cpol;
            mosi_q     <= head_bit(tx_aligned, lsb_in);
            cs_n_q     <= cs_dec_n;
            busy_q     <= 1'b1;
            tx_ready_q <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (div_tick) begin
            state_q <= ST_LEAD;
            sck_q   <= ~mode_q[1];
            if (!q_cpha) rx_q <= rx_shift;
          end
        end
        ST_LEAD: begin
          if (div_tick) begin
            state_q <= ST_TRAIL;
            sck_q   <= mode_q[1];
            cnt_q   <= cnt_inc;
            if (q_cpha) begin
              rx_q <= rx_shift;
            end else if (cnt_inc != n_q) begin
              sh_q   <= sh_shift;
              mosi_q <= head_bit(sh_shift, lsb_q);
            end
          end
        end
        ST_TRAIL: begin
          if (div_tick) begin
            if (cnt_q == n_q) begin
              state_q <= ST_HOLD;
            end else begin
              state_q <= ST_LEAD;
              sck_q   <= ~mode_q[1];
              if (!q_cpha) begin
                rx_q <= rx_shift;
              end else begin
                sh_q   <= sh_shift;
                mosi_q <= head_bit(sh_shift, lsb_q);
              end
            end
          end
        end
        ST_HOLD: begin
          if (div_tick) begin
            state_q    <= ST_DONE;
            cs_n_q     <= '1;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b1;
            rx_data_q  <= rx_q;
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          rx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          tx_ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi; LSB-first case runs when SPIM_LSB_FIRST_EN is defined.
module tb_spi_master_multi;

  logic        clk;
  logic        rst;
  logic [31:0] tx_data;
  logic [5:0]  bit_count;
  logic [1:0]  cs_sel;
  logic        cpol, cpha;
  logic [7:0]  clk_div;
  logic        lsb_first;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid, busy, sck, mosi;
  logic        miso;
  logic [3:0]  cs_n;
  logic        loop_en, miso_fix;

  int n_tests = 0;
  int n_fail  = 0;

  assign miso = loop_en ? mosi : miso_fix;

  spi_master_multi dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .bit_count (bit_count),
    .cs_sel    (cs_sel),
    .cpol      (cpol),
    .cpha      (cpha),
    .clk_div   (clk_div),
`ifdef SPIM_LSB_FIRST_EN
    .lsb_first (lsb_first),
`endif
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .sck       (sck),
    .mosi      (mosi),
    .miso      (miso),
    .cs_n      (cs_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one command and samples every negedge until rx_valid or timeout.
  task automatic run_frame(input string name, input logic [31:0] data, input logic [5:0] bc,
                           input logic [1:0] cs, input logic [1:0] mode, input logic [7:0] div,
                           output logic [31:0] rx, output int cs_low, output int rises,
                           output logic first_b, output logic last_b,
                           output logic [3:0] cs_seen, output logic got);
    logic prev_sck;
    for (int i = 0; i < 100 && !tx_ready; i++) @(negedge clk);
    tx_data = data; bit_count = bc; cs_sel = cs; {cpol, cpha} = mode; clk_div = div;
    tx_valid = 1'b1;
    prev_sck = sck;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    cs_low = 0; rises = 0; got = 1'b0; rx = '0; cs_seen = 4'hF; first_b = 1'b0; last_b = 1'b0;
    for (int c = 0; c < 5000 && !got; c++) begin
      @(negedge clk);
      if (c == 0) first_b = mosi;
      if (cs_n != 4'hF) begin
        cs_low++;
        cs_seen = cs_n;
        last_b  = mosi;
      end
      if (sck && !prev_sck) rises++;
      prev_sck = sck;
      if (rx_valid) begin
        got = 1'b1;
        rx  = rx_data;
      end
    end
    check({name, "_rx_valid_seen"}, got, 1'b1);
  endtask

  logic [31:0] rx;
  int          cs_low, rises;
  logic        first_b, last_b, got;
  logic [3:0]  cs_seen;

  initial begin
    rst = 1'b0; tx_valid = 1'b0; tx_data = '0; bit_count = '0; cs_sel = '0;
    cpol = 1'b0; cpha = 1'b0; clk_div = '0; lsb_first = 1'b0;
    loop_en = 1'b0; miso_fix = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 4'hF);
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_data", rx_data, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Mode 0, full 32-bit loopback
    loop_en = 1'b1;
    run_frame("m0_n32", 32'hA5A51234, 6'd32, 2'd0, 2'b00, 8'd0, rx, cs_low, rises, first_b, last_b, cs_seen, got);
    check("m0_n32_rx", rx, 32'hA5A51234);
    check("m0_n32_cs_low", cs_low, 66);
    check("m0_n32_rises", rises, 32);
    check("m0_n32_cs_seen", cs_seen, 4'b1110);
    check("m0_n32_first", first_b, 1'b1);

    // Mode 3, slave 2, miso tied high
    loop_en = 1'b0; miso_fix = 1'b1;
    run_frame("m3_n8", 32'h3C, 6'd8, 2'd2, 2'b11, 8'd3, rx, cs_low, rises, first_b, last_b, cs_seen, got);
    check("m3_n8_rx", rx, 32'h000000FF);
    check("m3_n8_cs_low", cs_low, 72);
    check("m3_n8_cs_seen", cs_seen, 4'b1011);
    check("m3_n8_first", first_b, 1'b0);
    check("m3_n8_sck_idle", sck, 1'b1);
    @(negedge clk);
    check("m3_n8_cs_idle", cs_n, 4'hF);

    // bit_count=0 means full width
    loop_en = 1'b1;
    run_frame("bc0", 32'h80000001, 6'd0, 2'd0, 2'b00, 8'd1, rx, cs_low, rises, first_b, last_b, cs_seen, got);
    check("bc0_rx", rx, 32'h80000001);
    check("bc0_first", first_b, 1'b1);
    check("bc0_last", last_b, 1'b1);
    check("bc0_rises", rises, 32);
    check("bc0_cs_low", cs_low, 132);
    check("bc0_sck_idle", sck, 1'b0);

    // Mode 1, 12 bits, slave 1
    run_frame("m1_n12", 32'hABC, 6'd12, 2'd1, 2'b01, 8'd2, rx, cs_low, rises, first_b, last_b, cs_seen, got);
    check("m1_n12_rx", rx, 32'h00000ABC);
    check("m1_n12_cs_low", cs_low, 78);
    check("m1_n12_cs_seen", cs_seen, 4'b1101);
    check("m1_n12_rises", rises, 12);

    // Mode 2, 5 bits, slave 3, miso low
    loop_en = 1'b0; miso_fix = 1'b0;
    run_frame("m2_n5", 32'h15, 6'd5, 2'd3, 2'b10, 8'd0, rx, cs_low, rises, first_b, last_b, cs_seen, got);
    check("m2_n5_rx", rx, 32'h0);
    check("m2_n5_cs_low", cs_low, 12);
    check("m2_n5_cs_seen", cs_seen, 4'b0111);
    check("m2_n5_first", first_b, 1'b1);

    // Back-to-back with tx_valid held
    begin
      int cyc, v1, c2, n_valid;
      logic dropped;
      loop_en = 1'b1;
      for (int i = 0; i < 100 && !tx_ready; i++) @(negedge clk);
      tx_data = 32'h9; bit_count = 6'd4; cs_sel = 2'd0; {cpol, cpha} = 2'b00; clk_div = 8'd0;
      tx_valid = 1'b1;
      v1 = -1; c2 = -1; n_valid = 0; dropped = 1'b0; rx = '0;
      for (cyc = 0; cyc < 300 && n_valid < 2; cyc++) begin
        @(negedge clk);
        if (rx_valid) begin
          n_valid++;
          rx = rx_data;
          if (v1 < 0) v1 = cyc;
        end
        if (v1 >= 0 && c2 < 0 && cs_n != 4'hF) begin
          c2 = cyc;
          tx_valid = 1'b0;
          dropped = 1'b1;
        end
      end
      tx_valid = 1'b0;
      check("b2b_two_frames", n_valid, 2);
      check("b2b_dropped", dropped, 1'b1);
      check("b2b_gap", c2 - v1, 2);
      check("b2b_rx", rx, 32'h9);
    end

    // Reset mid-frame at bit 5 of a 16-bit frame
    begin
      int r;
      logic seen_valid;
      loop_en = 1'b0; miso_fix = 1'b1;
      for (int i = 0; i < 100 && !tx_ready; i++) @(negedge clk);
      tx_data = 32'hFFFF; bit_count = 6'd16; cs_sel = 2'd1; {cpol, cpha} = 2'b00; clk_div = 8'd1;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      r = 0;
      for (int c = 0; c < 500 && r < 5; c++) begin
        @(negedge clk);
        if (sck) r++;
        while (sck && c < 500) begin @(negedge clk); c++; end
      end
      check("rst_mid_reached_bit5", r, 5);
      check("rst_mid_cs_active", cs_n, 4'b1101);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mid_cs_n", cs_n, 4'hF);
      check("rst_mid_sck", sck, 1'b0);
      check("rst_mid_mosi", mosi, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_tx_ready", tx_ready, 1'b1);
      check("rst_mid_rx_data", rx_data, 32'h0);
      seen_valid = rx_valid;
      repeat (3) begin
        @(negedge clk);
        seen_valid |= rx_valid;
      end
      rst = 1'b1;
      repeat (40) begin
        @(negedge clk);
        seen_valid |= rx_valid;
      end
      check("rst_mid_no_rx_valid", seen_valid, 1'b0);
      loop_en = 1'b1;
      run_frame("post_rst", 32'h5A, 6'd8, 2'd0, 2'b00, 8'd0, rx, cs_low, rises, first_b, last_b, cs_seen, got);
      check("post_rst_rx", rx, 32'h5A);
      check("post_rst_cs_low", cs_low, 18);
    end

`ifdef SPIM_LSB_FIRST_EN
    loop_en = 1'b1; lsb_first = 1'b1;
    run_frame("lsb_n8", 32'h01, 6'd8, 2'd0, 2'b00, 8'd0, rx, cs_low, rises, first_b, last_b, cs_seen, got);
    check("lsb_n8_rx", rx, 32'h01);
    check("lsb_n8_first", first_b, 1'b1);
    check("lsb_n8_last", last_b, 1'b0);
    loop_en = 1'b0; miso_fix = 1'b1;
    run_frame("lsb_n4_ones", 32'h0, 6'd4, 2'd0, 2'b01, 8'd1, rx, cs_low, rises, first_b, last_b, cs_seen, got);
    check("lsb_n4_ones_rx", rx, 32'h0F);
    lsb_first = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
